// File: rtl/dsp_fir_multiband.sv
// Three-band equaliser: complementary symmetric 9-tap FIRs split the input into
// low/mid/high bands, which are scaled by Q8 gains, summed and saturated.
module dsp_fir_multiband #(
    parameter logic signed [15:0] G_LOW  = 16'sd256,
    parameter logic signed [15:0] G_MID  = 16'sd256,
    parameter logic signed [15:0] G_HIGH = 16'sd256
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic signed [15:0] iIn,
    output logic signed [15:0] oOut
);

    localparam int unsigned Taps = 9;

    localparam logic signed [47:0] GainLow  = 48'(G_LOW);
    localparam logic signed [47:0] GainMid  = 48'(G_MID);
    localparam logic signed [47:0] GainHigh = 48'(G_HIGH);

    logic signed [15:0] x_q [Taps];

    logic signed [31:0] fold0, fold1, fold2, fold3, center;
    logic signed [31:0] low_d, mid_d, high_d;
    logic signed [31:0] low_q, mid_q, high_q;

    logic signed [47:0] acc;
    logic signed [47:0] y;
    logic signed [15:0] sat_d;

    // Stage 1: delay line
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < Taps; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            x_q[0] <= iIn;
            for (int k = 1; k < Taps; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    // All three kernels are even-symmetric, so mirrored taps are pre-added once.
    always_comb begin
        fold0  = 32'(x_q[0]) + 32'(x_q[8]);
        fold1  = 32'(x_q[1]) + 32'(x_q[7]);
        fold2  = 32'(x_q[2]) + 32'(x_q[6]);
        fold3  = 32'(x_q[3]) + 32'(x_q[5]);
        center = 32'(x_q[4]);

        low_d  = 32'sd4 * fold0 + 32'sd16 * fold1 + 32'sd32 * fold2
               + 32'sd48 * fold3 + 32'sd56 * center;
        mid_d  = 32'sd16 * fold3 + 32'sd40 * center
               - 32'sd4 * fold0 - 32'sd16 * fold1 - 32'sd16 * fold2;
        high_d = 32'sd160 * center - 32'sd64 * fold3 - 32'sd16 * fold2;
    end

    // Stage 2: band registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            low_q  <= '0;
            mid_q  <= '0;
            high_q <= '0;
        end else begin
            low_q  <= low_d;
            mid_q  <= mid_d;
            high_q <= high_d;
        end
    end

    // Q8 gains on Q8-scaled bands leave the sum at 2^16 times the sample scale.
    always_comb begin
        acc = GainLow * 48'(low_q) + GainMid * 48'(mid_q) + GainHigh * 48'(high_q);
        y   = acc >>> 16;
        if (y > 48'sd32767) begin
            sat_d = 16'sh7fff;
        end else if (y < -48'sd32768) begin
            sat_d = 16'sh8000;
        end else begin
            sat_d = y[15:0];
        end
    end

    // Stage 3: saturated output register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oOut <= '0;
        end else begin
            oOut <= sat_d;
        end
    end

endmodule

// File: tb/tb_dsp_fir_multiband.sv
// Bench for dsp_fir_multiband: five gain configurations share one stimulus
// stream and are checked against an input-history reference model.
module tb_dsp_fir_multiband;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] din = '0;
    logic signed [15:0] out_unity, out_low, out_mid, out_high, out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsp_fir_multiband u_unity (.iCLK(clk), .iRST(rst), .iIn(din), .oOut(out_unity));

    dsp_fir_multiband #(.G_LOW(16'sd256), .G_MID(16'sd0), .G_HIGH(16'sd0)) u_low (
        .iCLK(clk), .iRST(rst), .iIn(din), .oOut(out_low));

    dsp_fir_multiband #(.G_LOW(16'sd0), .G_MID(16'sd256), .G_HIGH(16'sd0)) u_mid (
        .iCLK(clk), .iRST(rst), .iIn(din), .oOut(out_mid));

    dsp_fir_multiband #(.G_LOW(16'sd0), .G_MID(16'sd0), .G_HIGH(16'sd256)) u_high (
        .iCLK(clk), .iRST(rst), .iIn(din), .oOut(out_high));

    dsp_fir_multiband #(.G_LOW(16'sd512), .G_MID(16'sd512), .G_HIGH(16'sd512)) u_sat (
        .iCLK(clk), .iRST(rst), .iIn(din), .oOut(out_sat));

    int hl [9] = '{4, 16, 32, 48, 56, 48, 32, 16, 4};
    int hm [9] = '{-4, -16, -16, 16, 40, 16, -16, -16, -4};
    int hh [9] = '{0, 0, -16, -64, 160, -64, -16, 0, 0};

    // hist[j] = sample taken j edges ago; a reset edge wipes all history.
    longint hist [11];

    task automatic step(input logic signed [15:0] v, input logic r);
        @(negedge clk);
        din = v;
        rst = r;
        @(posedge clk);
        for (int j = 10; j > 0; j--) hist[j] = r ? 64'sd0 : hist[j-1];
        hist[0] = r ? 64'sd0 : longint'(v);
        #1;
    endtask

    // Output at an edge depends on taps as they stood two edges earlier.
    function automatic logic signed [15:0] model_out(input longint gl, input longint gm,
                                                     input longint gh);
        longint lo = 0;
        longint mi = 0;
        longint hi = 0;
        longint acc;
        longint y;
        for (int j = 0; j < 9; j++) begin
            lo += longint'(hl[j]) * hist[j+2];
            mi += longint'(hm[j]) * hist[j+2];
            hi += longint'(hh[j]) * hist[j+2];
        end
        acc = gl * lo + gm * mi + gh * hi;
        y   = acc >>> 16;
        if (y > 32767) return 16'sh7fff;
        if (y < -32768) return 16'sh8000;
        return 16'(y);
    endfunction

    task automatic test_reset;
        for (int i = 0; i < 3; i++) step(16'($urandom), 1'b1);
        n_checks++; if (out_unity !== 16'sd0) begin n_fail++;
            $display("FAIL reset_unity: got %0d expected 0", out_unity); end
        n_checks++; if (out_low !== 16'sd0) begin n_fail++;
            $display("FAIL reset_low: got %0d expected 0", out_low); end
        n_checks++; if (out_mid !== 16'sd0) begin n_fail++;
            $display("FAIL reset_mid: got %0d expected 0", out_mid); end
        n_checks++; if (out_high !== 16'sd0) begin n_fail++;
            $display("FAIL reset_high: got %0d expected 0", out_high); end
        n_checks++; if (out_sat !== 16'sd0) begin n_fail++;
            $display("FAIL reset_sat: got %0d expected 0", out_sat); end
    endtask

    task automatic test_step_unity;
        logic signed [15:0] exp_v;
        step(16'sd0, 1'b1);
        for (int i = 0; i < 10; i++) step(16'sd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(16'sd100, 1'b0);
            exp_v = (i >= 6) ? 16'sd100 : 16'sd0;
            n_checks++;
            if (out_unity !== exp_v) begin
                n_fail++;
                $display("FAIL step_unity[k+%0d]: got %0d expected %0d", i, out_unity, exp_v);
            end
        end
    endtask

    task automatic test_random_delay;
        logic signed [15:0] e;
        for (int i = 0; i < 200; i++) begin
            step(16'($urandom), 1'b0);
            n_checks++;
            if (out_unity !== 16'(hist[6])) begin
                n_fail++;
                $display("FAIL rand_delay[%0d]: got %0d expected %0d", i, out_unity,
                         16'(hist[6]));
            end
            e = model_out(256, 0, 0);
            n_checks++; if (out_low !== e) begin n_fail++;
                $display("FAIL rand_low[%0d]: got %0d expected %0d", i, out_low, e); end
            e = model_out(0, 256, 0);
            n_checks++; if (out_mid !== e) begin n_fail++;
                $display("FAIL rand_mid[%0d]: got %0d expected %0d", i, out_mid, e); end
            e = model_out(0, 0, 256);
            n_checks++; if (out_high !== e) begin n_fail++;
                $display("FAIL rand_high[%0d]: got %0d expected %0d", i, out_high, e); end
            e = model_out(512, 512, 512);
            n_checks++; if (out_sat !== e) begin n_fail++;
                $display("FAIL rand_sat[%0d]: got %0d expected %0d", i, out_sat, e); end
        end
    endtask

    task automatic test_lowpass_step;
        logic signed [15:0] got [16];
        logic signed [15:0] e;
        int tbl [9] = '{1, 7, 20, 39, 60, 79, 92, 98, 100};
        int f = -1;
        step(16'sd0, 1'b1);
        for (int i = 0; i < 10; i++) step(16'sd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(16'sd100, 1'b0);
            got[i] = out_low;
            e = model_out(256, 0, 0);
            n_checks++;
            if (out_low !== e) begin
                n_fail++;
                $display("FAIL lp_step_model[%0d]: got %0d expected %0d", i, out_low, e);
            end
        end
        for (int i = 0; i < 16; i++) if (f < 0 && got[i] !== 16'sd0) f = i;
        n_checks++;
        if (f < 0 || f > 6) begin
            n_fail++;
            $display("FAIL lp_step_start: got first nonzero index %0d expected 0..6", f);
        end else begin
            for (int i = 0; f + i < 16; i++) begin
                e = (i < 9) ? 16'(tbl[i]) : 16'sd100;
                n_checks++;
                if (got[f+i] !== e) begin
                    n_fail++;
                    $display("FAIL lp_step_seq[%0d]: got %0d expected %0d", i, got[f+i], e);
                end
            end
        end
    endtask

    task automatic test_band_reject;
        step(16'sd0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step((i % 2 == 0) ? 16'sd100 : -16'sd100, 1'b0);
            if (i >= 12) begin
                n_checks++; if (out_low !== 16'sd0) begin n_fail++;
                    $display("FAIL alt_low[%0d]: got %0d expected 0", i, out_low); end
                n_checks++; if (out_mid !== 16'sd0) begin n_fail++;
                    $display("FAIL alt_mid[%0d]: got %0d expected 0", i, out_mid); end
                n_checks++; if (out_high !== 16'(hist[6])) begin n_fail++;
                    $display("FAIL alt_high[%0d]: got %0d expected %0d", i, out_high,
                             16'(hist[6])); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(16'sd100, 1'b0);
            if (i >= 12) begin
                n_checks++; if (out_high !== 16'sd0) begin n_fail++;
                    $display("FAIL dc_high[%0d]: got %0d expected 0", i, out_high); end
            end
        end
    endtask

    task automatic test_saturation;
        step(16'sd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(16'sd30000, 1'b0);
            if (i >= 6) begin
                n_checks++; if (out_sat !== 16'sh7fff) begin n_fail++;
                    $display("FAIL sat_pos[%0d]: got %0d expected 32767", i, out_sat); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(-16'sd30000, 1'b0);
            if (i >= 6) begin
                n_checks++; if (out_sat !== 16'sh8000) begin n_fail++;
                    $display("FAIL sat_neg[%0d]: got %0d expected -32768", i, out_sat); end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic signed [15:0] post [21];
        logic signed [15:0] e;
        for (int i = 0; i < 30; i++) step(16'($urandom), 1'b0);
        step(16'($urandom), 1'b1);
        n_checks++; if (out_unity !== 16'sd0) begin n_fail++;
            $display("FAIL midrst_edge: got %0d expected 0", out_unity); end
        for (int i = 1; i <= 20; i++) begin
            post[i] = 16'($urandom);
            step(post[i], 1'b0);
            e = (i <= 6) ? 16'sd0 : post[i-6];
            n_checks++;
            if (out_unity !== e) begin
                n_fail++;
                $display("FAIL midrst_unity[r+%0d]: got %0d expected %0d", i, out_unity, e);
            end
            e = model_out(0, 0, 256);
            n_checks++;
            if (out_high !== e) begin
                n_fail++;
                $display("FAIL midrst_high[r+%0d]: got %0d expected %0d", i, out_high, e);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 11; j++) hist[j] = 0;
        test_reset();
        test_step_unity();
        test_random_delay();
        test_lowpass_step();
        test_band_reject();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
